// File: rtl/mac_pkg.sv
// Shared width, saturation and lane-slicing helpers for the pipelined MAC engine.
// Everything here is elaboration-time arithmetic; nothing in it is clocked.
package mac_pkg;

    function automatic int clog2_f(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w + 1;
    endfunction

    // Both limits are built at 64 bits and truncated to ACC_W by the caller.
    function automatic logic signed [63:0] sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/mac_accum_pipe_if.sv
// Beat input and result output handshake bundle of the MAC engine.
// The master side is the producer of beats and the consumer of results.
interface mac_accum_pipe_if #(
    parameter int LANES = 4,
    parameter int A_W   = 16,
    parameter int B_W   = 8,
    parameter int ACC_W = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*A_W-1:0]   in_a;
    logic [LANES*B_W-1:0]   in_b;
    logic                   in_clear;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;
    logic                   out_sat;

    modport master (
        output in_valid, in_a, in_b, in_clear, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_clear, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/mac_lane_mult.sv
// One lane: registered signed weight times zero-extended unsigned pixel.
// Shaped to land in a single DSP multiplier with its output register.
module mac_lane_mult
    import mac_pkg::*;
#(
    parameter int A_W = 16,
    parameter int B_W = 8,
    parameter int P_W = prod_w(A_W, B_W)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  en,
    input  logic signed [A_W-1:0] a,
    input  logic        [B_W-1:0] b,
    output logic signed [P_W-1:0] p
);
    logic signed [B_W:0]   b_ext_s;
    logic signed [P_W-1:0] prod_s;
    logic signed [P_W-1:0] p_r;

    assign b_ext_s = signed'({1'b0, b});
    assign prod_s  = a * b_ext_s;
    assign p       = p_r;

    // product register, frozen while the pipeline is stalled
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            p_r <= {P_W{1'b0}};
        end else if (en) begin
            p_r <= prod_s;
        end
    end
endmodule

// File: rtl/mac_accum_pipe.sv
// Three-stage multiply / reduce / saturating-accumulate engine producing one
// result per DEPTH beats; a single global stall freezes every stage.
module mac_accum_pipe
    import mac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int A_W   = 16,
    parameter int B_W   = 8,
    parameter int ACC_W = 32,
    parameter int DEPTH = 16
) (
    input logic             ap_clk,
    input logic             ap_rst,
    mac_accum_pipe_if.slave bus
);
    localparam int P_W   = prod_w(A_W, B_W);
    localparam int CNT_W = clog2_f(DEPTH + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));
    localparam logic [CNT_W-1:0]        DEPTH_C = CNT_W'(DEPTH);

    logic                    stall_s, adv_s, accept_s;
    logic                    s1_valid_r, s1_clear_r, s2_valid_r, s2_clear_r;
    logic signed [P_W-1:0]   p_s [LANES];
    logic signed [ACC_W-1:0] sum_s, s2_sum_r, acc_r, base_s, clamp_s, out_data_r;
    logic signed [ACC_W:0]   next_s;
    logic                    ovf_s;
    logic [CNT_W-1:0]        cnt_r, cnt_next_s;
    logic                    sticky_r, sticky_s, done_s, out_valid_r, out_sat_r;

    assign stall_s       = out_valid_r && !bus.out_ready;
    assign adv_s         = !stall_s;
    assign accept_s      = bus.in_valid && adv_s;
    assign bus.in_ready  = adv_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sat   = out_sat_r;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane_mult #(.A_W(A_W), .B_W(B_W)) u_mult (
            .ap_clk (ap_clk),
            .ap_rst (ap_rst),
            .en     (adv_s),
            .a      (bus.in_a[lane_lsb(i, A_W) +: A_W]),
            .b      (bus.in_b[lane_lsb(i, B_W) +: B_W]),
            .p      (p_s[i])
        );
    end

    // S1 control bits travelling alongside the lane products
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid_r <= 1'b0;
            s1_clear_r <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r <= accept_s;
            s1_clear_r <= bus.in_clear && accept_s;
        end
    end

    // reduction of sign-extended lane products; ACC_W leaves headroom for every lane
    always_comb begin
        sum_s = {ACC_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + ACC_W'(p_s[i]);
        end
    end

    // S2 register holding the reduced beat sum
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s2_valid_r <= 1'b0;
            s2_clear_r <= 1'b0;
            s2_sum_r   <= {ACC_W{1'b0}};
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
            s2_clear_r <= s1_clear_r;
            s2_sum_r   <= sum_s;
        end
    end

    // accumulate one bit wider than the result so overflow shows up as a sign disagreement
    always_comb begin
        base_s = s2_clear_r ? {ACC_W{1'b0}} : acc_r;
        next_s = (ACC_W+1)'(base_s) + (ACC_W+1)'(s2_sum_r);
        ovf_s  = next_s[ACC_W] != next_s[ACC_W-1];
        if (ovf_s) begin
            clamp_s = next_s[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            clamp_s = next_s[ACC_W-1:0];
        end
        sticky_s   = (s2_clear_r ? 1'b0 : sticky_r) || ovf_s;
        cnt_next_s = s2_clear_r ? CNT_W'(1) : cnt_r + CNT_W'(1);
        done_s     = s2_valid_r && (cnt_next_s == DEPTH_C);
    end

    // S3 accumulator, group counter and result register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            sticky_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {ACC_W{1'b0}};
            out_sat_r   <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= done_s;
            if (done_s) begin
                out_data_r <= clamp_s;
                out_sat_r  <= sticky_s;
                acc_r      <= {ACC_W{1'b0}};
                cnt_r      <= {CNT_W{1'b0}};
                sticky_r   <= 1'b0;
            end else if (s2_valid_r) begin
                acc_r    <= clamp_s;
                cnt_r    <= cnt_next_s;
                sticky_r <= sticky_s;
            end
        end
    end
endmodule
